// File: rtl/regalu_pkg.sv
// ============================================================================
// Module   : regalu_pkg
// Brief    : Shared ALU opcode encoding and architectural register addresses
//            for the regfile/ALU pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

package regalu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    localparam int A0_ADDR   = 10;
    localparam int ZERO_ADDR = 0;

endpackage

`default_nettype wire

// File: rtl/regfile_alu_pipe_regfile.sv
// ============================================================================
// Module   : regfile_2r1w
// Brief    : Two async read ports, one sync write port, async clear, x0 = 0,
//            plus a fixed-address observation port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_2r1w
    import regalu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int OBS_ADDR   = A0_ADDR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] raddr1_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    input  logic [ADDR_WIDTH-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata2_o,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] obs_o
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_ZERO = ADDR_WIDTH'(ZERO_ADDR);

    logic [DATA_WIDTH-1:0] r_mem_q [NUM_REGS];

    // Entry 0 is cleared on reset and never written, so it always reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != C_ZERO)) begin
            r_mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == C_ZERO) ? '0 : r_mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == C_ZERO) ? '0 : r_mem_q[raddr2_i];
    assign obs_o    = r_mem_q[OBS_ADDR];

endmodule

`default_nettype wire

// File: rtl/regfile_alu_pipe.sv
// ============================================================================
// Module   : regfile_alu_pipe
// Brief    : Two-stage (EX -> WB) regfile + operand mux + ALU datapath with
//            WB bypass, a0 observation and retired-instruction counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_alu_pipe
    import regalu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    input  logic [ADDR_WIDTH-1:0] rs1_i,
    input  logic [ADDR_WIDTH-1:0] rs2_i,
    input  logic [ADDR_WIDTH-1:0] rd_i,
    input  logic                  reg_wen_i,
    input  logic                  alu_src_i,
    input  logic [DATA_WIDTH-1:0] imm_op_i,
    input  logic [2:0]            alu_ctrl_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] alu_out_o,
    output logic                  eq_o,
    output logic [DATA_WIDTH-1:0] a0_o,
    output logic [CNT_WIDTH-1:0]  retire_count_o
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] C_ZERO = ADDR_WIDTH'(ZERO_ADDR);

    logic                  r_out_valid_q;
    logic [DATA_WIDTH-1:0] r_alu_out_q;
    logic                  r_eq_q;
    logic [ADDR_WIDTH-1:0] r_rd_q;
    logic                  r_wen_q;
    logic [CNT_WIDTH-1:0]  r_retire_q;

    logic                  w_wb_commit;
    logic [DATA_WIDTH-1:0] w_rf_rdata1;
    logic [DATA_WIDTH-1:0] w_rf_rdata2;
    logic [DATA_WIDTH-1:0] w_op1;
    logic [DATA_WIDTH-1:0] w_rs2_val;
    logic [DATA_WIDTH-1:0] w_op2;
    logic [DATA_WIDTH-1:0] w_alu_d;
    logic                  w_eq_d;
    logic [SHAMT_W-1:0]    w_shamt;
    alu_op_t               w_op;

    // The same condition gates the regfile write and both bypass paths.
    assign w_wb_commit = r_out_valid_q && r_wen_q && (r_rd_q != C_ZERO);

    regfile_2r1w #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .OBS_ADDR   (A0_ADDR)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1_i (rs1_i),
        .rdata1_o (w_rf_rdata1),
        .raddr2_i (rs2_i),
        .rdata2_o (w_rf_rdata2),
        .we_i     (w_wb_commit),
        .waddr_i  (r_rd_q),
        .wdata_i  (r_alu_out_q),
        .obs_o    (a0_o)
    );

    assign w_op1     = (w_wb_commit && (r_rd_q == rs1_i)) ? r_alu_out_q : w_rf_rdata1;
    assign w_rs2_val = (w_wb_commit && (r_rd_q == rs2_i)) ? r_alu_out_q : w_rf_rdata2;
    assign w_op2     = alu_src_i ? imm_op_i : w_rs2_val;
    assign w_shamt   = w_op2[SHAMT_W-1:0];
    assign w_op      = alu_op_t'(alu_ctrl_i);
    assign w_eq_d    = (w_op1 == w_op2);

    always_comb begin
        w_alu_d = '0;
        case (w_op)
            ALU_ADD: w_alu_d = w_op1 + w_op2;
            ALU_SUB: w_alu_d = w_op1 - w_op2;
            ALU_AND: w_alu_d = w_op1 & w_op2;
            ALU_OR:  w_alu_d = w_op1 | w_op2;
            ALU_XOR: w_alu_d = w_op1 ^ w_op2;
            ALU_SLL: w_alu_d = w_op1 << w_shamt;
            ALU_SRL: w_alu_d = w_op1 >> w_shamt;
            ALU_SLT: w_alu_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
            default: w_alu_d = '0;
        endcase
    end

    // Bubbles only clear out_valid; the data registers hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid_q <= 1'b0;
            r_alu_out_q   <= '0;
            r_eq_q        <= 1'b0;
            r_rd_q        <= '0;
            r_wen_q       <= 1'b0;
        end else begin
            r_out_valid_q <= in_valid_i;
            if (in_valid_i) begin
                r_alu_out_q <= w_alu_d;
                r_eq_q      <= w_eq_d;
                r_rd_q      <= rd_i;
                r_wen_q     <= reg_wen_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_q <= '0;
        end else if (r_out_valid_q) begin
            r_retire_q <= r_retire_q + 1'b1;
        end
    end

    assign out_valid_o    = r_out_valid_q;
    assign alu_out_o      = r_alu_out_q;
    assign eq_o           = r_eq_q;
    assign retire_count_o = r_retire_q;

endmodule

`default_nettype wire
